// File: rtl/fxp_div_pkg.sv
// Shared types and helpers for the sequential fixed-point divider.
package fxp_div_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Width of a counter that must hold the values 0..iterations.
  function automatic int cnt_width(input int iterations);
    return (iterations < 2) ? 1 : $clog2(iterations + 1);
  endfunction

endpackage

// File: rtl/fxp_div_post.sv
// Post-processing of the raw unsigned quotient: round, apply sign, saturate.
// The quotient carries one extra LSB that serves as the round bit.
module fxp_div_post
  import fxp_div_pkg::*;
#(
  parameter int WO    = 16,
  parameter int ROUND = 1
) (
  input  logic [WO:0]   q,
  input  logic          sign,
  input  logic          ovf,
  output logic [WO-1:0] res,
  output logic          sat
);

  localparam int N = WO + 1;
  // Largest positive magnitude and largest negative magnitude, N bits wide.
  localparam logic [N-1:0] POS_LIM = {2'b00, {(WO-1){1'b1}}};
  localparam logic [N-1:0] NEG_LIM = {2'b01, {(WO-1){1'b0}}};

  logic [N-1:0] mag;
  logic [N-1:0] rnd_inc;
  logic [N-1:0] neg_mag;

  // Round, detect saturation and produce the signed result.
  always_comb begin
    rnd_inc = {N{1'b0}};
    if (ROUND != 0) begin
      rnd_inc = {{(N-1){1'b0}}, q[0]};
    end else begin
      rnd_inc = {N{1'b0}};
    end
    // q >> 1 plus the round bit cannot exceed N bits.
    mag     = {1'b0, q[N-1:1]} + rnd_inc;
    neg_mag = -mag;
    sat     = ovf | (~sign & (mag > POS_LIM)) | (sign & (mag > NEG_LIM));
    if (sat) begin
      if (sign) begin
        res = NEG_LIM[WO-1:0];
      end else begin
        res = POS_LIM[WO-1:0];
      end
    end else if (sign) begin
      res = neg_mag[WO-1:0];
    end else begin
      res = mag[WO-1:0];
    end
  end

endmodule

// File: rtl/fxp_div_seq.sv
// Sequential signed fixed-point divider, restoring long division, one
// quotient bit per cycle, fixed latency of N+2 cycles from vld to rdy.
module fxp_div_seq
  import fxp_div_pkg::*;
#(
  parameter int WIIA  = 8,
  parameter int WIFA  = 8,
  parameter int WIIB  = 8,
  parameter int WIFB  = 8,
  parameter int WOI   = 8,
  parameter int WOF   = 8,
  parameter int ROUND = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIIA+WIFA-1:0] ina,
  input  logic [WIIB+WIFB-1:0] inb,
  input  logic                 vld,
  output logic                 busy,
  output logic                 rdy,
  output logic [WOI+WOF-1:0]   out,
  output logic                 overflow
);

  localparam int WA = WIIA + WIFA;
  localparam int WB = WIIB + WIFB;
  localparam int WO = WOI + WOF;
  localparam int N  = WO + 1;              // quotient bits incl. round bit
  localparam int SH = WIFB + WOF + 1;      // dividend pre-shift
  localparam int WD = WA + 1 + SH;         // width of scaled dividend D
  localparam int WH = WD - N;              // width of D >> N
  localparam int WV = WB + 1 + WIFA;       // width of scaled divisor V
  localparam int WR = ((WH > WV) ? WH : WV) + 1;
  localparam int CW = cnt_width(N);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [WR-1:0] rem;
  logic [N-1:0]  dlo;
  logic [WV-1:0] vreg;
  logic [N-1:0]  quot;
  logic          sign;
  logic          ovf;

  logic [WA:0]   abs_a;
  logic [WB:0]   abs_b;
  logic [WD-1:0] d_full;
  logic [WV-1:0] v_full;
  logic          entry_ovf;
  logic [WR-1:0] rem_sh;
  logic [WR-1:0] v_ext;
  logic          take;
  logic [WR-1:0] rem_nx;
  logic [WO-1:0] post_res;
  logic          post_sat;

  // Operand magnitudes, scaling and the quotient-range precheck.
  always_comb begin
    abs_a     = ina[WA-1] ? -{ina[WA-1], ina} : {ina[WA-1], ina};
    abs_b     = inb[WB-1] ? -{inb[WB-1], inb} : {inb[WB-1], inb};
    d_full    = {abs_a, {SH{1'b0}}};
    v_full    = {abs_b, {WIFA{1'b0}}};
    // If the top part of D already reaches V the quotient needs more than N bits.
    entry_ovf = (inb == {WB{1'b0}}) |
                ({{(WR-WH){1'b0}}, d_full[WD-1:N]} >= {{(WR-WV){1'b0}}, v_full});
  end

  // One restoring step: shift in the next dividend bit and trial-subtract.
  always_comb begin
    v_ext  = {{(WR-WV){1'b0}}, vreg};
    rem_sh = {rem[WR-2:0], dlo[N-1]};
    take   = (rem_sh >= v_ext);
    if (take) begin
      rem_nx = rem_sh - v_ext;
    end else begin
      rem_nx = rem_sh;
    end
  end

  fxp_div_post #(
    .WO   (WO),
    .ROUND(ROUND)
  ) u_post (
    .q   (quot),
    .sign(sign),
    .ovf (ovf),
    .res (post_res),
    .sat (post_sat)
  );

  // Control FSM with datapath registers and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= {CW{1'b0}};
      rem      <= {WR{1'b0}};
      dlo      <= {N{1'b0}};
      vreg     <= {WV{1'b0}};
      quot     <= {N{1'b0}};
      sign     <= 1'b0;
      ovf      <= 1'b0;
      busy     <= 1'b0;
      rdy      <= 1'b0;
      out      <= {WO{1'b0}};
      overflow <= 1'b0;
    end else begin
      rdy <= 1'b0;
      case (state)
        S_IDLE: begin
          if (vld) begin
            // A zero divisor saturates on the dividend sign alone.
            if (inb == {WB{1'b0}}) begin
              sign <= ina[WA-1];
            end else begin
              sign <= ina[WA-1] ^ inb[WB-1];
            end
            rem   <= {{(WR-WH){1'b0}}, d_full[WD-1:N]};
            dlo   <= d_full[N-1:0];
            vreg  <= v_full;
            quot  <= {N{1'b0}};
            ovf   <= entry_ovf;
            cnt   <= {CW{1'b0}};
            busy  <= 1'b1;
            state <= S_CALC;
          end else begin
            state <= S_IDLE;
          end
        end
        S_CALC: begin
          rem  <= rem_nx;
          dlo  <= {dlo[N-2:0], 1'b0};
          quot <= {quot[N-2:0], take};
          cnt  <= cnt + 1'b1;
          if (cnt == CW'(N - 1)) begin
            state <= S_DONE;
          end else begin
            state <= S_CALC;
          end
        end
        S_DONE: begin
          out      <= post_res;
          overflow <= post_sat;
          rdy      <= 1'b1;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fxp_div_seq.sv
// Self-checking bench for fxp_div_seq: a rounding and a truncating instance
// are driven with the same stimulus and compared every cycle against an
// arithmetic reference model.
module tb_fxp_div_seq;

  localparam int N   = 17;
  localparam int LAT = N + 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        vld;
  logic [15:0] ina;
  logic [15:0] inb;
  logic        busy_r, rdy_r, ovf_r;
  logic        busy_t, rdy_t, ovf_t;
  logic [15:0] out_r, out_t;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit checking = 1'b0;

  typedef struct {
    int          rdy_cyc;
    logic [16:0] exp_r;
    logic [16:0] exp_t;
  } job_t;

  job_t        jobs[$];
  logic [16:0] held_r = 17'd0;
  logic [16:0] held_t = 17'd0;

  always #5 clk = ~clk;

  fxp_div_seq #(.ROUND(1)) dut_r (
    .clk(clk), .rst(rst), .ina(ina), .inb(inb), .vld(vld),
    .busy(busy_r), .rdy(rdy_r), .out(out_r), .overflow(ovf_r)
  );

  fxp_div_seq #(.ROUND(0)) dut_t (
    .clk(clk), .rst(rst), .ina(ina), .inb(inb), .vld(vld),
    .busy(busy_t), .rdy(rdy_t), .out(out_t), .overflow(ovf_t)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference: value of a/b in Q8.8, returned as {overflow, out}.
  function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b, input bit rnd);
    longint sa, sb, aa, bb, q, mag, res;
    bit neg, sat;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    aa  = (sa < 0) ? -sa : sa;
    bb  = (sb < 0) ? -sb : sb;
    mag = 0;
    sat = 1'b0;
    if (sb == 0) begin
      sat = 1'b1;
      neg = (sa < 0);
    end else begin
      neg = ((sa < 0) != (sb < 0));
      // quotient in units of 2^-9: one bit finer than the output
      q = (aa * 512) / bb;
      if (q >= (64'sd1 << N)) sat = 1'b1;
      else begin
        mag = q / 2 + ((rnd && (q % 2 == 1)) ? 1 : 0);
        if (neg ? (mag > 32768) : (mag > 32767)) sat = 1'b1;
      end
    end
    if (sat) res = neg ? -32768 : 32767;
    else     res = neg ? -mag : mag;
    return {sat, res[15:0]};
  endfunction

  function automatic logic [15:0] pick();
    logic [15:0] edges [6] = '{16'h0000, 16'h8000, 16'h7FFF, 16'hFFFF, 16'h0001, 16'h0100};
    case ($urandom_range(0, 3))
      0: return edges[$urandom_range(0, 5)];
      1: return 16'($signed(10'($urandom)));
      default: return 16'($urandom);
    endcase
  endfunction

  // Model: accept requests at the rising edge when no division is in flight.
  initial forever begin
    @(posedge clk);
    if (rst) begin
      jobs.delete();
      held_r   = 17'd0;
      held_t   = 17'd0;
      checking = 1'b1;
    end else if (checking && vld && jobs.size() == 0) begin
      jobs.push_back('{rdy_cyc: cyc + LAT, exp_r: model(ina, inb, 1'b1), exp_t: model(ina, inb, 1'b0)});
    end
    cyc++;
  end

  // Compare process: every cycle on the falling edge.
  initial forever begin
    @(negedge clk);
    if (checking) begin
      bit er, eb;
      er = (jobs.size() != 0) && (jobs[0].rdy_cyc == cyc);
      eb = (jobs.size() != 0) && !er;
      if (er) begin
        held_r = jobs[0].exp_r;
        held_t = jobs[0].exp_t;
        void'(jobs.pop_front());
      end
      check("rdy_round", 32'(rdy_r), 32'(er));
      check("rdy_trunc", 32'(rdy_t), 32'(er));
      check("busy_round", 32'(busy_r), 32'(eb));
      check("busy_trunc", 32'(busy_t), 32'(eb));
      check("result_round", 32'({ovf_r, out_r}), 32'(held_r));
      check("result_trunc", 32'({ovf_t, out_t}), 32'(held_t));
    end
  end

  task automatic issue(input logic [15:0] a, input logic [15:0] b, output int lat);
    ina = a;
    inb = b;
    vld = 1'b1;
    lat = -1;
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      @(posedge clk); #1;
      vld = 1'b0;
      if (rdy_r) lat = k;
    end
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [16:0] er;
    logic [16:0] et;
  } vec_t;

  vec_t dir [8] = '{
    '{16'h0600, 16'h0200, 17'h00300, 17'h00300},
    '{16'hF880, 16'h0200, 17'h0FC40, 17'h0FC40},
    '{16'h0200, 16'h0300, 17'h000AB, 17'h000AA},
    '{16'h0100, 16'h0300, 17'h00055, 17'h00055},
    '{16'h6400, 16'h0080, 17'h17FFF, 17'h17FFF},
    '{16'h8000, 16'hFF00, 17'h17FFF, 17'h17FFF},
    '{16'hFF00, 16'h0000, 17'h18000, 17'h18000},
    '{16'h0000, 16'hFF00, 17'h00000, 17'h00000}
  };

  initial begin
    int lat, cnt;
    rst = 1'b1;
    vld = 1'b0;
    ina = 16'h0000;
    inb = 16'h0000;

    // Pin the reference model to hand-computed results.
    foreach (dir[i]) begin
      check("model_round", 32'(model(dir[i].a, dir[i].b, 1'b1)), 32'(dir[i].er));
      check("model_trunc", 32'(model(dir[i].a, dir[i].b, 1'b0)), 32'(dir[i].et));
    end

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_out", 32'({ovf_r, out_r, busy_r, rdy_r}), 32'd0);

    // Directed vectors with literal expectations and latency.
    foreach (dir[i]) begin
      issue(dir[i].a, dir[i].b, lat);
      check("latency", 32'(lat), 32'(LAT));
      check("dir_round", 32'({ovf_r, out_r}), 32'(dir[i].er));
      check("dir_trunc", 32'({ovf_t, out_t}), 32'(dir[i].et));
    end

    // vld held high: one result per LAT cycles, nothing extra.
    @(posedge clk); #1;
    vld = 1'b1;
    cnt = 0;
    for (int i = 0; i < 3 * LAT + 1; i++) begin
      if (rdy_r) cnt++;
      ina = pick();
      inb = pick();
      @(posedge clk); #1;
    end
    vld = 1'b0;
    check("held_vld_rdy_count", 32'(cnt), 32'd3);
    repeat (LAT + 1) @(posedge clk);
    #1;

    // Reset in cycle 10 of a division aborts it.
    ina = 16'h0600;
    inb = 16'h0200;
    vld = 1'b1;
    @(posedge clk); #1;
    vld = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_out", 32'({ovf_r, out_r, busy_r}), 32'd0);
    cnt = 0;
    repeat (LAT) begin
      if (rdy_r) cnt++;
      @(posedge clk); #1;
    end
    check("abort_no_rdy", 32'(cnt), 32'd0);
    issue(16'h0600, 16'h0200, lat);
    check("after_abort_latency", 32'(lat), 32'(LAT));
    check("after_abort_out", 32'({ovf_r, out_r}), 32'h00300);

    // Random traffic, including vld while busy and occasional resets.
    for (int i = 0; i < 2500; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      vld = ($urandom_range(0, 2) == 0);
      ina = pick();
      inb = pick();
      @(posedge clk); #1;
    end
    rst = 1'b0;
    vld = 1'b0;
    repeat (LAT + 3) @(posedge clk);
    #1;
    check("drained", 32'(jobs.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
